// File: rtl/adc_accum_6b_pkg.sv
// Shared types and constants for the 6-bit ADC accumulator and its row-range decoder.
package adc_accum_6b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] MAX_ROWS = 5'd16;
  localparam logic [4:0] ROWS_9   = 5'd9;
  localparam logic [4:0] ROWS_5   = 5'd5;
  localparam logic [4:0] ROWS_3   = 5'd3;
  localparam logic [4:0] ROWS_2   = 5'd2;
  localparam logic [4:0] ROWS_1   = 5'd1;

  localparam logic [7:0] SUM_CAP  = 8'd63;

  // Clip an 8-bit frame sum to the 6-bit quantizer input range.
  function automatic logic [5:0] sat6(input logic [7:0] s);
    return (s > SUM_CAP) ? 6'd63 : s[5:0];
  endfunction

endpackage

// File: rtl/adc_accum_6b_rows_range_decode.sv
// Combinational decode of active row count into one-hot quantizer range selects.
module rows_range_decode
  import adc_accum_6b_pkg::*;
(
  input  logic [4:0] rows,
  output logic       m16to9,
  output logic       m8to5,
  output logic       m4to3,
  output logic       m2,
  output logic       m1,
  output logic       err
);

  logic legal;

  // Illegal counts zero every select so the outputs can never go multi-hot.
  assign legal  = (rows >= ROWS_1) && (rows <= MAX_ROWS);
  assign err    = !legal;
  assign m16to9 = legal && (rows >= ROWS_9);
  assign m8to5  = legal && (rows >= ROWS_5) && (rows < ROWS_9);
  assign m4to3  = legal && (rows >= ROWS_3) && (rows < ROWS_5);
  assign m2     = legal && (rows == ROWS_2);
  assign m1     = legal && (rows == ROWS_1);

endmodule

// File: rtl/adc_accum_6b.sv
// Frame accumulator: sums 4-bit ADC samples, saturates to 6 bits, and holds the result for the quantizer.
module adc_accum_6b
  import adc_accum_6b_pkg::*;
#(
  parameter int MAX_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_load,
  input  logic [4:0] cfg_rows,
  input  logic       cfg_col_en,
  input  logic       adc_valid,
  input  logic [3:0] adc_code,
  input  logic       adc_last,
  output logic       adc_ready,
  output logic       acc_valid,
  input  logic       acc_ready,
  output logic [5:0] acc_data,
  output logic       acc_sat,
  output logic       col_en,
  output logic       matrix_16to9,
  output logic       matrix_8to5,
  output logic       matrix_4to3,
  output logic       matrix_2,
  output logic       matrix_1,
  output logic       cfg_err,
  output logic       busy
);

  localparam int CW = $clog2(MAX_SAMPLES + 1);

  state_t        state, state_nxt;
  logic [7:0]    sum, sum_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          d16to9, d8to5, d4to3, d2, d1, derr;

  rows_range_decode u_dec (
    .rows   (cfg_rows),
    .m16to9 (d16to9),
    .m8to5  (d8to5),
    .m4to3  (d4to3),
    .m2     (d2),
    .m1     (d1),
    .err    (derr)
  );

  assign adc_ready = (state != HOLD);
  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (adc_valid) begin
        sum_nxt   = {4'b0, adc_code};
        cnt_nxt   = CW'(1);
        state_nxt = (adc_last || cnt_nxt == CW'(MAX_SAMPLES)) ? HOLD : ACCUM;
      end
      ACCUM: if (adc_valid) begin
        sum_nxt   = sum + {4'b0, adc_code};
        cnt_nxt   = cnt + CW'(1);
        state_nxt = (adc_last || cnt_nxt == CW'(MAX_SAMPLES)) ? HOLD : ACCUM;
      end
      HOLD: if (acc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sum          <= '0;
      cnt          <= '0;
      acc_data     <= '0;
      acc_sat      <= 1'b0;
      col_en       <= 1'b0;
      matrix_16to9 <= 1'b0;
      matrix_8to5  <= 1'b0;
      matrix_4to3  <= 1'b0;
      matrix_2     <= 1'b0;
      matrix_1     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      cnt   <= cnt_nxt;
      // Result is captured once on HOLD entry and frozen until handed off.
      if (state != HOLD && state_nxt == HOLD) begin
        acc_data <= sat6(sum_nxt);
        acc_sat  <= (sum_nxt > SUM_CAP);
      end
      if (state == IDLE && cfg_load) begin
        col_en       <= cfg_col_en;
        matrix_16to9 <= d16to9;
        matrix_8to5  <= d8to5;
        matrix_4to3  <= d4to3;
        matrix_2     <= d2;
        matrix_1     <= d1;
        cfg_err      <= derr;
      end
    end
  end

endmodule
